// File: rtl/linear_layer_fifo_pkg.sv
// Shared types and parameter checks for the Linear_Layer shallow SRL FIFOs.
// The parameter-check macro is placed inside a module body that declares DEPTH and ADDR_WIDTH.
package linear_layer_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

`define LL_FIFO_PARAM_CHECK(depth_, addr_w_) \
  if ((depth_) < 2) begin : g_depth_chk \
    $error("linear_layer FIFO: DEPTH must be at least 2"); \
  end \
  if ((addr_w_) < linear_layer_fifo_pkg::clog2(depth_)) begin : g_addr_w_chk \
    $error("linear_layer FIFO: ADDR_WIDTH too narrow for DEPTH"); \
  end

// File: rtl/linear_layer_srl_store.sv
// Shift-register data store: a write enters slot 0 and pushes older words up one slot.
module linear_layer_srl_store
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// Show-ahead FIFO controller for start tokens / small words between Linear_Layer processes.
// Owns the head pointer, occupancy count and registered full/empty flags around an SRL store.
module linear_layer_start_fifo_srl_ctrl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  `LL_FIFO_PARAM_CHECK(DEPTH, ADDR_WIDTH)

  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  fifo_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full_n_q, empty_n_q;
  logic                  push, pop;

  assign push = if_write_ce & if_write & full_n_q;
  assign pop  = if_read_ce & if_read & empty_n_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: begin
        if (push) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop) begin
          ptr_d = ptr_q + 1'b1;
          if (count_q == CNT_LAST) state_d = FULL;
        end else if (pop && !push) begin
          if (ptr_q == '0) state_d = EMPTY;
          else             ptr_d   = ptr_q - 1'b1;
        end
      end
      FULL: begin
        // push cannot occur here since full_n_q is low; a simultaneous write is dropped
        if (pop) begin
          state_d = PARTIAL;
          ptr_d   = ptr_q - 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Flags come straight from the next state so they are glitch-free registers
  always_ff @(posedge clk) begin
    if (reset) begin
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      empty_n_q <= (state_d != EMPTY);
      full_n_q  <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !push) begin
      count_q <= count_q - 1'b1;
    end
  end

  linear_layer_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .we  (push & ~reset),
    .addr(ptr_q),
    .din (if_din),
    .dout(if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl_ctrl.sv
// Scoreboard bench: a DEPTH=2 and a DEPTH=3 instance, directed stimulus, monitors check popped data.
module tb_linear_layer_start_fifo_srl_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=2 instance
  logic       a_reset, a_full_n, a_write_ce, a_write, a_empty_n, a_read_ce, a_read;
  logic [7:0] a_din, a_dout;
  logic [1:0] a_count;
  // DEPTH=3 instance
  logic       b_reset, b_full_n, b_write_ce, b_write, b_empty_n, b_read_ce, b_read;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_count;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  linear_layer_start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_a (
    .clk(clk), .reset(a_reset), .if_full_n(a_full_n), .if_write_ce(a_write_ce),
    .if_write(a_write), .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(a_read_ce),
    .if_read(a_read), .if_dout(a_dout), .if_num_data_valid(a_count)
  );

  linear_layer_start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(3)) u_b (
    .clk(clk), .reset(b_reset), .if_full_n(b_full_n), .if_write_ce(b_write_ce),
    .if_write(b_write), .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(b_read_ce),
    .if_read(b_read), .if_dout(b_dout), .if_num_data_valid(b_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a pop happens on the cycle the DUT presents a valid head and the read is enabled
  always @(negedge clk) begin
    if (!a_reset && a_read_ce && a_read && a_empty_n) begin
      if (qa.size() == 0) chk("a_pop_underflow", 32'd1, 32'd0);
      else                chk("a_pop_data", {24'd0, a_dout}, {24'd0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!b_reset && b_read_ce && b_read && b_empty_n) begin
      if (qb.size() == 0) chk("b_pop_underflow", 32'd1, 32'd0);
      else                chk("b_pop_data", {24'd0, b_dout}, {24'd0, qb.pop_front()});
    end
  end

  initial begin
    a_reset = 1'b1; a_write_ce = 1'b1; a_write = 1'b0; a_din = '0; a_read_ce = 1'b1; a_read = 1'b0;
    b_reset = 1'b1; b_write_ce = 1'b1; b_write = 1'b0; b_din = '0; b_read_ce = 1'b1; b_read = 1'b0;
    tick();
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;
    chk("a_rst_empty_n", a_empty_n, 0);
    chk("a_rst_full_n", a_full_n, 1);
    chk("a_rst_count", a_count, 0);
    chk("b_rst_empty_n", b_empty_n, 0);

    // single write then read
    a_write = 1'b1; a_din = 8'hA5; qa.push_back(8'hA5);
    tick();
    a_write = 1'b0;
    chk("a_wr1_empty_n", a_empty_n, 1);
    chk("a_wr1_count", a_count, 1);
    chk("a_wr1_dout", a_dout, 8'hA5);
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    chk("a_rd1_empty_n", a_empty_n, 0);
    chk("a_rd1_count", a_count, 0);

    // fill to full, overflow write ignored, drain in order
    a_write = 1'b1; a_din = 8'h11; qa.push_back(8'h11);
    tick();
    chk("a_fill_full_n_mid", a_full_n, 1);
    a_din = 8'h22; qa.push_back(8'h22);
    tick();
    chk("a_fill_full_n", a_full_n, 0);
    chk("a_fill_count", a_count, 2);
    a_din = 8'h33;
    tick();
    a_write = 1'b0;
    chk("a_ovf_count", a_count, 2);
    chk("a_ovf_full_n", a_full_n, 0);
    chk("a_ovf_head", a_dout, 8'h11);
    a_read = 1'b1;
    tick();
    chk("a_drain_full_n", a_full_n, 1);
    tick();
    a_read = 1'b0;
    chk("a_drain_empty_n", a_empty_n, 0);
    chk("a_drain_count", a_count, 0);

    // write+read while full: only the pop applies
    a_write = 1'b1; a_din = 8'h44; qa.push_back(8'h44);
    tick();
    a_din = 8'h55; qa.push_back(8'h55);
    tick();
    a_din = 8'h66; a_read = 1'b1;
    tick();
    a_write = 1'b0; a_read = 1'b0;
    chk("a_fwr_count", a_count, 1);
    chk("a_fwr_full_n", a_full_n, 1);
    chk("a_fwr_head", a_dout, 8'h55);
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    chk("a_fwr_empty_n", a_empty_n, 0);

    // clock-enables low block both requests
    a_write = 1'b1; a_din = 8'h77; qa.push_back(8'h77);
    tick();
    a_write_ce = 1'b0; a_read_ce = 1'b0; a_read = 1'b1; a_din = 8'h88;
    tick();
    tick();
    chk("a_ce_count", a_count, 1);
    chk("a_ce_empty_n", a_empty_n, 1);
    chk("a_ce_full_n", a_full_n, 1);
    chk("a_ce_head", a_dout, 8'h77);
    a_write = 1'b0; a_write_ce = 1'b1; a_read_ce = 1'b1;
    tick();
    a_read = 1'b0;
    chk("a_ce_drain_count", a_count, 0);

    // reset with two entries and a push in flight
    a_write = 1'b1; a_din = 8'h99;
    tick();
    a_din = 8'hAA;
    tick();
    chk("a_pre_rst_count", a_count, 2);
    a_din = 8'hBB; a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_write = 1'b0;
    chk("a_mid_rst_count", a_count, 0);
    chk("a_mid_rst_empty_n", a_empty_n, 0);
    chk("a_mid_rst_full_n", a_full_n, 1);
    a_write = 1'b1; a_din = 8'hCC; qa.push_back(8'hCC);
    tick();
    a_write = 1'b0;
    chk("a_post_rst_count", a_count, 1);
    chk("a_post_rst_head", a_dout, 8'hCC);
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    chk("a_post_rst_empty_n", a_empty_n, 0);

    // DEPTH=3: steady-state push+pop keeps occupancy at one
    b_write = 1'b1; b_din = 8'h01; qb.push_back(8'h01);
    tick();
    b_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_din = 8'(i + 2); qb.push_back(8'(i + 2));
      tick();
      chk("b_stream_count", b_count, 1);
      chk("b_stream_empty_n", b_empty_n, 1);
      chk("b_stream_full_n", b_full_n, 1);
      chk("b_stream_head", b_dout, 32'(i + 2));
    end
    b_write = 1'b0;
    tick();
    b_read = 1'b0;
    chk("b_end_empty_n", b_empty_n, 0);
    chk("b_end_count", b_count, 0);

    // DEPTH=3 fills to exactly three entries
    b_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_din = 8'(8'hD0 + i); qb.push_back(8'(8'hD0 + i));
      tick();
    end
    b_write = 1'b0;
    chk("b_full_count", b_count, 3);
    chk("b_full_full_n", b_full_n, 0);
    b_read = 1'b1;
    tick();
    tick();
    tick();
    b_read = 1'b0;
    chk("b_full_drain_empty_n", b_empty_n, 0);

    tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
